// File: rtl/wb_stage_if.sv
// MEM->WB handshake bundle.
//   mem2wb_bus   : {id_multiply, wdest[4:0], we, mem_result[31:0], dm_addr[31:0], pc[31:0]}
//   mem2wb_valid : MEM stage holds a valid instruction
//   wb_allowin   : WB accepts the bus at this clock edge
// master = MEM stage side, slave = WB stage side.
interface wb_stage_if;
    logic [102:0] mem2wb_bus;
    logic         mem2wb_valid;
    logic         wb_allowin;

    modport master (output mem2wb_bus, output mem2wb_valid, input  wb_allowin);
    modport slave  (input  mem2wb_bus, input  mem2wb_valid, output wb_allowin);
endinterface

// File: rtl/wb_stage.sv
// Write-back stage. Holds one instruction from MEM and drives the register-file
// write port, ID forwarding, hazard/controller status and the debug trace.
// Multiply instructions wait for the multi-cycle multiplier and retire with its
// product in place of mem_result.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mem2wb (slave)               MEM->WB bus / valid / allowin
//   mul_result_i, mul_valid_i    multiplier product and its 1-cycle strobe
//   rf_we_o/rf_waddr_o/rf_wdata_o                register-file write port
//   forward_wb2id_data_o/_valid_o                forwarding to ID
//   ctl_wb_dest_o, ctl_wb_over_o                 hazard/controller status
//   mul_err_o                                    sticky multiplier error
//   debug_wb_pc_o/_rf_wen_o/_rf_wnum_o/_rf_wdata_o   debug trace
module wb_stage #(
    parameter int MUL_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    wb_stage_if.slave   mem2wb,
    input  logic [31:0] mul_result_i,
    input  logic        mul_valid_i,
    output logic        rf_we_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o,
    output logic [31:0] forward_wb2id_data_o,
    output logic        forward_wb2id_valid_o,
    output logic [4:0]  ctl_wb_dest_o,
    output logic        ctl_wb_over_o,
    output logic        mul_err_o,
    output logic [31:0] debug_wb_pc_o,
    output logic [3:0]  debug_wb_rf_wen_o,
    output logic [4:0]  debug_wb_rf_wnum_o,
    output logic [31:0] debug_wb_rf_wdata_o
);
    localparam int CNT_W = (MUL_TIMEOUT > 2) ? $clog2(MUL_TIMEOUT) : 1;

    typedef enum logic [1:0] {EMPTY, RETIRE, WAIT_MUL, MUL_RETIRE} state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_res;
    logic        r_we;
    logic [4:0]  r_wdest;
    logic [31:0] r_mul_wdata;
    logic [31:0] r_buf;
    logic        r_buf_vld;
    logic [CNT_W-1:0] r_cnt;
    logic        r_mul_err;

    // Bus field split
    logic        w_bus_mul;
    logic [4:0]  w_bus_wdest;
    logic        w_bus_we;
    logic [31:0] w_bus_res;
    logic [31:0] w_bus_pc;
    logic        w_unused_dm_addr;

    assign w_bus_mul        = mem2wb.mem2wb_bus[102];
    assign w_bus_wdest      = mem2wb.mem2wb_bus[101:97];
    assign w_bus_we         = mem2wb.mem2wb_bus[96];
    assign w_bus_res        = mem2wb.mem2wb_bus[95:64];
    assign w_bus_pc         = mem2wb.mem2wb_bus[31:0];
    assign w_unused_dm_addr = ^mem2wb.mem2wb_bus[63:32];

    logic w_allowin, w_accept, w_retiring, w_occupied, w_buf_consume;
    logic [31:0] w_wdata;

    // All outputs are forced low during the reset cycle, hence the !rst terms.
    assign w_allowin     = !rst && (r_state != WAIT_MUL);
    assign w_accept      = mem2wb.mem2wb_valid && w_allowin;
    assign w_retiring    = !rst && (r_state == RETIRE || r_state == MUL_RETIRE);
    assign w_occupied    = !rst && (r_state != EMPTY);
    assign w_buf_consume = (r_state == WAIT_MUL) && r_buf_vld;
    assign w_wdata       = (r_state == MUL_RETIRE) ? r_mul_wdata : r_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= EMPTY;
            r_pc        <= '0;
            r_res       <= '0;
            r_we        <= 1'b0;
            r_wdest     <= '0;
            r_mul_wdata <= '0;
            r_buf       <= '0;
            r_buf_vld   <= 1'b0;
            r_cnt       <= '0;
            r_mul_err   <= 1'b0;
        end else begin
            case (r_state)
                WAIT_MUL: begin
                    if (r_buf_vld) begin
                        // Buffered early result takes priority over a new strobe.
                        r_mul_wdata <= r_buf;
                        r_cnt       <= '0;
                        r_state     <= MUL_RETIRE;
                    end else if (mul_valid_i) begin
                        r_mul_wdata <= mul_result_i;
                        r_cnt       <= '0;
                        r_state     <= MUL_RETIRE;
                    end else if (r_cnt == CNT_W'(MUL_TIMEOUT - 1)) begin
                        r_mul_wdata <= '0;
                        r_mul_err   <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= MUL_RETIRE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    if (w_accept) begin
                        r_pc    <= w_bus_pc;
                        r_res   <= w_bus_res;
                        r_we    <= w_bus_we;
                        r_wdest <= w_bus_wdest;
                        r_cnt   <= '0;
                        r_state <= w_bus_mul ? WAIT_MUL : RETIRE;
                    end else begin
                        r_state <= EMPTY;
                    end
                end
            endcase

            // One-entry early-result buffer. A strobe seen in WAIT_MUL with an
            // empty buffer is consumed directly above and not stored.
            if (mul_valid_i) begin
                if (r_state == WAIT_MUL && !r_buf_vld) begin
                    r_buf_vld <= 1'b0;
                end else if (r_buf_vld && !w_buf_consume) begin
                    r_mul_err <= 1'b1;      // overflow: new value dropped
                end else begin
                    r_buf     <= mul_result_i;
                    r_buf_vld <= 1'b1;
                end
            end else if (w_buf_consume) begin
                r_buf_vld <= 1'b0;
            end
        end
    end

    assign mem2wb.wb_allowin = w_allowin;

    assign rf_we_o               = w_retiring && r_we && (r_wdest != 5'd0);
    assign rf_waddr_o            = rf_we_o ? r_wdest : 5'd0;
    assign rf_wdata_o            = rf_we_o ? w_wdata : 32'd0;
    assign forward_wb2id_data_o  = rf_wdata_o;
    assign forward_wb2id_valid_o = w_retiring;
    assign ctl_wb_dest_o         = (w_occupied && r_we) ? r_wdest : 5'd0;
    assign ctl_wb_over_o         = w_retiring;
    assign mul_err_o             = !rst && r_mul_err;
    assign debug_wb_pc_o         = w_retiring ? r_pc : 32'd0;
    assign debug_wb_rf_wen_o     = {4{rf_we_o}};
    assign debug_wb_rf_wnum_o    = rf_waddr_o;
    assign debug_wb_rf_wdata_o   = rf_wdata_o;
endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mul_result_i;
    logic        mul_valid_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic [31:0] forward_wb2id_data_o;
    logic        forward_wb2id_valid_o;
    logic [4:0]  ctl_wb_dest_o;
    logic        ctl_wb_over_o;
    logic        mul_err_o;
    logic [31:0] debug_wb_pc_o;
    logic [3:0]  debug_wb_rf_wen_o;
    logic [4:0]  debug_wb_rf_wnum_o;
    logic [31:0] debug_wb_rf_wdata_o;

    int n_vec = 0;
    int n_bad = 0;

    wb_stage_if bif();

    wb_stage #(.MUL_TIMEOUT(64)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .mem2wb                (bif.slave),
        .mul_result_i          (mul_result_i),
        .mul_valid_i           (mul_valid_i),
        .rf_we_o               (rf_we_o),
        .rf_waddr_o            (rf_waddr_o),
        .rf_wdata_o            (rf_wdata_o),
        .forward_wb2id_data_o  (forward_wb2id_data_o),
        .forward_wb2id_valid_o (forward_wb2id_valid_o),
        .ctl_wb_dest_o         (ctl_wb_dest_o),
        .ctl_wb_over_o         (ctl_wb_over_o),
        .mul_err_o             (mul_err_o),
        .debug_wb_pc_o         (debug_wb_pc_o),
        .debug_wb_rf_wen_o     (debug_wb_rf_wen_o),
        .debug_wb_rf_wnum_o    (debug_wb_rf_wnum_o),
        .debug_wb_rf_wdata_o   (debug_wb_rf_wdata_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [102:0] mk(input logic mul, input logic [4:0] wd,
                                        input logic we, input logic [31:0] res,
                                        input logic [31:0] pc);
        return {mul, wd, we, res, 32'hDEAD_0000, pc};
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, ".we"},   {31'd0, rf_we_o}, 32'd0);
        chk({tag, ".over"}, {31'd0, ctl_wb_over_o}, 32'd0);
    endtask

    initial begin
        int waits;
        rst = 1'b1;
        bif.mem2wb_valid = 1'b0;
        bif.mem2wb_bus   = '0;
        mul_valid_i  = 1'b0;
        mul_result_i = '0;
        tick();
        tick();
        // Reset cycle: every output low
        chk("rst.allowin", {31'd0, bif.wb_allowin}, 32'd0);
        chk("rst.we",      {31'd0, rf_we_o}, 32'd0);
        chk("rst.over",    {31'd0, ctl_wb_over_o}, 32'd0);
        chk("rst.err",     {31'd0, mul_err_o}, 32'd0);
        chk("rst.pc",      debug_wb_pc_o, 32'd0);
        chk("rst.fwdv",    {31'd0, forward_wb2id_valid_o}, 32'd0);
        rst = 1'b0;
        #1;
        chk("empty.allowin", {31'd0, bif.wb_allowin}, 32'd1);

        // 1: single add
        bif.mem2wb_bus   = mk(1'b0, 5'd5, 1'b1, 32'h1234, 32'h100);
        bif.mem2wb_valid = 1'b1;
        tick();
        bif.mem2wb_valid = 1'b0;
        chk("t1.we",    {31'd0, rf_we_o}, 32'd1);
        chk("t1.waddr", {27'd0, rf_waddr_o}, 32'd5);
        chk("t1.wdata", rf_wdata_o, 32'h1234);
        chk("t1.over",  {31'd0, ctl_wb_over_o}, 32'd1);
        chk("t1.pc",    debug_wb_pc_o, 32'h100);
        chk("t1.wen",   {28'd0, debug_wb_rf_wen_o}, 32'hF);
        chk("t1.fwd",   forward_wb2id_data_o, 32'h1234);
        chk("t1.fwdv",  {31'd0, forward_wb2id_valid_o}, 32'd1);
        chk("t1.dest",  {27'd0, ctl_wb_dest_o}, 32'd5);
        tick();
        chk_idle("t1.empty");

        // 2: three back-to-back
        for (int i = 0; i < 3; i++) begin
            bif.mem2wb_bus   = mk(1'b0, 5'(i + 1), 1'b1, 32'h10 + 32'(i), 32'h200 + 32'(4 * i));
            bif.mem2wb_valid = 1'b1;
            tick();
            chk("t2.we",      {31'd0, rf_we_o}, 32'd1);
            chk("t2.waddr",   {27'd0, rf_waddr_o}, 32'(i + 1));
            chk("t2.wdata",   rf_wdata_o, 32'h10 + 32'(i));
            chk("t2.allowin", {31'd0, bif.wb_allowin}, 32'd1);
        end
        bif.mem2wb_valid = 1'b0;
        tick();
        chk_idle("t2.empty");

        // 3: mul, result 3 cycles after accept
        bif.mem2wb_bus   = mk(1'b1, 5'd7, 1'b1, 32'h5555, 32'h300);
        bif.mem2wb_valid = 1'b1;
        tick();
        bif.mem2wb_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("t3.allowin", {31'd0, bif.wb_allowin}, 32'd0);
            chk("t3.we",      {31'd0, rf_we_o}, 32'd0);
            chk("t3.fwdv",    {31'd0, forward_wb2id_valid_o}, 32'd0);
            chk("t3.dest",    {27'd0, ctl_wb_dest_o}, 32'd7);
            tick();
        end
        mul_valid_i  = 1'b1;
        mul_result_i = 32'hCAFE;
        tick();
        mul_valid_i = 1'b0;
        chk("t3.we",      {31'd0, rf_we_o}, 32'd1);
        chk("t3.waddr",   {27'd0, rf_waddr_o}, 32'd7);
        chk("t3.wdata",   rf_wdata_o, 32'hCAFE);
        chk("t3.pc",      debug_wb_pc_o, 32'h300);
        chk("t3.allowin", {31'd0, bif.wb_allowin}, 32'd1);
        tick();

        // 4: early result buffered before the mul arrives
        mul_valid_i  = 1'b1;
        mul_result_i = 32'hBEEF;
        tick();
        mul_valid_i = 1'b0;
        chk_idle("t4.pre");
        bif.mem2wb_bus   = mk(1'b1, 5'd9, 1'b1, 32'h0, 32'h400);
        bif.mem2wb_valid = 1'b1;
        tick();
        bif.mem2wb_valid = 1'b0;
        chk("t4.allowin", {31'd0, bif.wb_allowin}, 32'd0);
        tick();
        chk("t4.we",    {31'd0, rf_we_o}, 32'd1);
        chk("t4.waddr", {27'd0, rf_waddr_o}, 32'd9);
        chk("t4.wdata", rf_wdata_o, 32'hBEEF);
        chk("t4.err",   {31'd0, mul_err_o}, 32'd0);
        tick();

        // Simultaneous consume + new strobe: old used, new kept for next mul
        mul_valid_i  = 1'b1;
        mul_result_i = 32'h1111;
        tick();
        mul_valid_i = 1'b0;
        bif.mem2wb_bus   = mk(1'b1, 5'd10, 1'b1, 32'h0, 32'h500);
        bif.mem2wb_valid = 1'b1;
        tick();
        bif.mem2wb_valid = 1'b0;
        mul_valid_i  = 1'b1;
        mul_result_i = 32'h2222;
        tick();
        mul_valid_i = 1'b0;
        chk("sim.wdata1", rf_wdata_o, 32'h1111);
        bif.mem2wb_bus   = mk(1'b1, 5'd11, 1'b1, 32'h0, 32'h504);
        bif.mem2wb_valid = 1'b1;
        tick();
        bif.mem2wb_valid = 1'b0;
        tick();
        chk("sim.waddr2", {27'd0, rf_waddr_o}, 32'd11);
        chk("sim.wdata2", rf_wdata_o, 32'h2222);
        chk("sim.err",    {31'd0, mul_err_o}, 32'd0);
        tick();

        // 6: write to x0 suppressed, still retires
        bif.mem2wb_bus   = mk(1'b0, 5'd0, 1'b1, 32'h7777, 32'h600);
        bif.mem2wb_valid = 1'b1;
        tick();
        bif.mem2wb_valid = 1'b0;
        chk("x0.we",   {31'd0, rf_we_o}, 32'd0);
        chk("x0.over", {31'd0, ctl_wb_over_o}, 32'd1);
        chk("x0.pc",   debug_wb_pc_o, 32'h600);
        chk("x0.fwd",  forward_wb2id_data_o, 32'd0);
        tick();

        // 5: multiplier timeout
        bif.mem2wb_bus   = mk(1'b1, 5'd12, 1'b1, 32'h9999, 32'h700);
        bif.mem2wb_valid = 1'b1;
        tick();
        bif.mem2wb_valid = 1'b0;
        waits = 0;
        while (!ctl_wb_over_o && waits < 200) begin
            tick();
            waits++;
        end
        chk("to.waits", 32'(waits), 32'd64);
        chk("to.we",    {31'd0, rf_we_o}, 32'd1);
        chk("to.wdata", rf_wdata_o, 32'd0);
        chk("to.err",   {31'd0, mul_err_o}, 32'd1);
        tick();
        tick();
        chk("to.sticky", {31'd0, mul_err_o}, 32'd1);

        // rst during WAIT_MUL
        bif.mem2wb_bus   = mk(1'b1, 5'd13, 1'b1, 32'h0, 32'h800);
        bif.mem2wb_valid = 1'b1;
        tick();
        bif.mem2wb_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("wrst.allowin", {31'd0, bif.wb_allowin}, 32'd0);
        chk("wrst.dest",    {27'd0, ctl_wb_dest_o}, 32'd0);
        tick();
        chk("wrst.err", {31'd0, mul_err_o}, 32'd0);
        chk_idle("wrst");
        rst = 1'b0;
        tick();
        chk_idle("wrst.after");
        chk("wrst.allowin2", {31'd0, bif.wb_allowin}, 32'd1);

        // Buffer overflow: two early strobes with no consumer
        mul_valid_i  = 1'b1;
        mul_result_i = 32'hA;
        tick();
        chk("ovf.err0", {31'd0, mul_err_o}, 32'd0);
        mul_result_i = 32'hB;
        tick();
        mul_valid_i = 1'b0;
        chk("ovf.err1", {31'd0, mul_err_o}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
